// File: rtl/throw_pkg.sv
// Shared types for the throw path: meter FSM states and force limits.
package throw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        THROW,
        COOLDOWN
    } throw_state_t;

    localparam int unsigned FORCE_MAX_DEF = 100;
    localparam int unsigned FORCE_W       = 10;
    localparam int unsigned ARITH_W       = 11;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clk cycles.
module tick_gen #(
    parameter int unsigned DIV = 650000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/throw_force_meter.sv
// Oscillating throw-force meter: charge on press, latch on release,
// request a throw and hold off re-arming until the button is let go.
module throw_force_meter
    import throw_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 650000,
    parameter int unsigned FORCE_STEP    = 2,
    parameter int unsigned FORCE_MAX     = FORCE_MAX_DEF,
    parameter int unsigned THROW_TIMEOUT = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn,
    input  logic               turn_active,
    input  logic               throw_done,
    output logic [FORCE_W-1:0] throw_force,
    output logic               enable,
    output logic               charging
);

    localparam int unsigned TW = $clog2(THROW_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(THROW_TIMEOUT - 1);
    localparam logic [ARITH_W-1:0] STEP = ARITH_W'(FORCE_STEP);
    localparam logic [ARITH_W-1:0] FMAX = ARITH_W'(FORCE_MAX);

    logic tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic btn_s1, btn_s2, btn_d;
    logic started, armed;
    logic press, release_ev;

    // armed only once a low level is sampled after reset,
    // so a button held through reset never reads as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_d   <= 1'b0;
            started <= 1'b0;
            armed   <= 1'b0;
        end else begin
            btn_s1  <= btn;
            btn_s2  <= btn_s1;
            btn_d   <= btn_s2;
            started <= 1'b1;
            armed   <= armed | (started & ~btn_s1);
        end
    end

    assign press      = btn_s2 & ~btn_d & armed;
    assign release_ev = ~btn_s2 & btn_d;

    throw_state_t       state, state_nxt;
    logic [FORCE_W-1:0] force_nxt;
    logic               dir_dn, dir_nxt;
    logic [TW-1:0]      tcnt, tcnt_nxt;
    logic               cd_tick, cd_nxt;
    logic [ARITH_W-1:0] f_ext, up_sum;

    assign f_ext  = {1'b0, throw_force};
    assign up_sum = f_ext + STEP;

    always_comb begin
        state_nxt = state;
        force_nxt = throw_force;
        dir_nxt   = dir_dn;
        tcnt_nxt  = tcnt;
        cd_nxt    = cd_tick;
        unique case (state)
            IDLE: begin
                if (press && turn_active) begin
                    state_nxt = CHARGE;
                    force_nxt = '0;
                    dir_nxt   = 1'b0;
                end
            end
            CHARGE: begin
                if (!turn_active) begin
                    state_nxt = IDLE;
                    force_nxt = '0;
                end else if (release_ev) begin
                    state_nxt = THROW;
                    tcnt_nxt  = '0;
                end else if (tick && !dir_dn) begin
                    if (up_sum >= FMAX) begin
                        force_nxt = FORCE_W'(FMAX);
                        dir_nxt   = 1'b1;
                    end else begin
                        force_nxt = up_sum[FORCE_W-1:0];
                    end
                end else if (tick) begin
                    if (f_ext <= STEP) begin
                        force_nxt = '0;
                        dir_nxt   = 1'b0;
                    end else begin
                        force_nxt = FORCE_W'(f_ext - STEP);
                    end
                end
            end
            THROW: begin
                if (throw_done || (tick && tcnt == T_LAST)) begin
                    state_nxt = COOLDOWN;
                    cd_nxt    = 1'b0;
                end else if (tick) begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    cd_nxt = 1'b1;
                end
                if (!btn_s2 && (cd_tick || tick)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs come straight from flops so reset can't glitch them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            throw_force <= '0;
            dir_dn      <= 1'b0;
            tcnt        <= '0;
            cd_tick     <= 1'b0;
            enable      <= 1'b0;
            charging    <= 1'b0;
        end else begin
            state       <= state_nxt;
            throw_force <= force_nxt;
            dir_dn      <= dir_nxt;
            tcnt        <= tcnt_nxt;
            cd_tick     <= cd_nxt;
            enable      <= (state_nxt == THROW);
            charging    <= (state_nxt == CHARGE);
        end
    end

endmodule

// File: tb/tb_throw_force_meter.sv
// Scoreboard bench: two meters (step 2 and step 3) share one stimulus.
module tb_throw_force_meter;

    localparam int TD = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic turn = 1'b1;
    logic done = 1'b0;
    logic [9:0] f2, f3;
    logic en2, en3, ch2, ch3;

    throw_force_meter #(
        .TICK_DIV(TD), .FORCE_STEP(2),
        .FORCE_MAX(100), .THROW_TIMEOUT(TO)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .turn_active(turn), .throw_done(done),
        .throw_force(f2), .enable(en2), .charging(ch2)
    );

    throw_force_meter #(
        .TICK_DIV(TD), .FORCE_STEP(3),
        .FORCE_MAX(100), .THROW_TIMEOUT(TO)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .turn_active(turn), .throw_done(done),
        .throw_force(f3), .enable(en3), .charging(ch3)
    );

    always #5 clk = ~clk;

    // posedges since reset release; ticks land on multiples of TD
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int f2;
        int f3;
        int rise;
        int fall;
    } exp_t;

    exp_t q[$];

    function automatic int model_force(input int ticks, input int step);
        int f = 0;
        bit up = 1;
        for (int i = 0; i < ticks; i++) begin
            if (up) begin
                f += step;
                if (f >= 100) begin f = 100; up = 0; end
            end else begin
                f -= step;
                if (f <= 0) begin f = 0; up = 1; end
            end
        end
        return f;
    endfunction

    // tick edges strictly between edges lo and hi
    function automatic int ticks_between(input int lo, input int hi);
        return (hi - 1) / TD - lo / TD;
    endfunction

    // monitor: enable edges are the DUT's output events
    exp_t cur;
    bit active = 0;
    bit prev_en = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            active = 0;
            prev_en = 0;
        end else begin
            if (en2 && !prev_en) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_enable at cyc %0d", cyc);
                end else begin
                    cur = q.pop_front();
                    active = 1;
                    chk("force_s2", int'(f2), cur.f2);
                    chk("force_s3", int'(f3), cur.f3);
                    chk("rise_cyc", cyc, cur.rise);
                    chk("charging_off", int'(ch2), 0);
                    chk("enable_s3", int'(en3), 1);
                end
            end else if (!en2 && prev_en && active) begin
                chk("fall_cyc", cyc, cur.fall);
                chk("enable_s3_off", int'(en3), 0);
                active = 0;
            end
            prev_en = en2;
        end
    end

    task automatic start_throw(input int hold, input int dly,
                               output int r_e, output int f_e);
        int c, p_e, k, to_e, d_e;
        exp_t x;
        @(negedge clk);
        btn = 1'b1;
        c = cyc;
        p_e = c + 3;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == hold / 2) chk("charging_mid", int'(ch2), 1);
        end
        btn = 1'b0;
        r_e = c + hold + 3;
        k = ticks_between(p_e, r_e);
        to_e = (r_e / TD + 1) * TD + TD * (TO - 1);
        d_e = r_e + dly + 1;
        f_e = (dly >= 0 && d_e < to_e) ? d_e : to_e;
        x.f2 = model_force(k, 2);
        x.f3 = model_force(k, 3);
        x.rise = r_e;
        x.fall = f_e;
        q.push_back(x);
    endtask

    task automatic finish_throw(input int r_e, input int f_e,
                                input int dly);
        int last;
        last = f_e;
        if (dly >= 0) begin
            while (cyc < r_e + dly) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            if (r_e + dly + 1 > last) last = r_e + dly + 1;
        end
        while (cyc < last + 12) @(negedge clk);
    endtask

    task automatic do_throw(input int hold, input int dly);
        int r_e, f_e;
        start_throw(hold, dly, r_e, f_e);
        finish_throw(r_e, f_e, dly);
    endtask

    initial begin
        int r_e, f_e;
        #23;
        chk("rst_force", int'(f2), 0);
        chk("rst_enable", int'(en2), 0);
        chk("rst_charging", int'(ch2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 10, 60, 34, 35 ticks of charge
        do_throw(41, 20);
        do_throw(241, -1);
        do_throw(137, 8);
        do_throw(141, 0);

        for (int n = 0; n < 10; n++) begin
            int h, d;
            h = int'($urandom_range(8, 500));
            d = ($urandom_range(0, 1) == 0) ? -1
                : int'($urandom_range(0, 100));
            do_throw(h, d);
        end

        // press while turn inactive is ignored
        turn = 1'b0;
        btn = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_turn_idle", int'(ch2), 0);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        turn = 1'b1;
        repeat (4) @(negedge clk);

        // turn lost mid-charge drops back to idle with zero force
        btn = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_charging", int'(ch2), 1);
        turn = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_idle", int'(ch2), 0);
        chk("abort_force", int'(f2), 0);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        turn = 1'b1;
        repeat (4) @(negedge clk);

        // button regrabbed during throw and held through cooldown
        start_throw(45, -1, r_e, f_e);
        while (cyc < r_e + 3) @(negedge clk);
        btn = 1'b1;
        finish_throw(r_e, f_e, -1);
        repeat (30) @(negedge clk);
        chk("held_no_charge", int'(ch2), 0);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        do_throw(57, 10);

        // async reset mid-throw, button held through reset
        start_throw(41, -1, r_e, f_e);
        while (cyc < r_e + 2) @(negedge clk);
        chk("pre_rst_enable", int'(en2), 1);
        btn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_enable", int'(en2), 0);
        chk("async_force", int'(f2), 0);
        chk("async_force_s3", int'(f3), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_rst_no_press", int'(ch2), 0);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        do_throw(41, 3);

        chk("queue_drained", q.size(), 0);
        chk("no_open_throw", int'(active), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/throw_force_meter.md
THROW_FORCE_METER -- requirements
Module: throw_force_meter

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- TICK_DIV, 650000: clk cycles per meter tick (10 ms at 65 MHz).
- FORCE_STEP, 2: force change per tick.
- FORCE_MAX, 100: upper force bound.
- THROW_TIMEOUT, 500: ticks before a throw is abandoned.

REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk, input, 1: single system clock.
- rst_n, input, 1: asynchronous active-low reset.
- btn, input, 1: raw throw button, asynchronous to clk.
- turn_active, input, 1: player's turn; gates arming.
- throw_done, input, 1: one-cycle pulse from the downstream throw controller when the projectile has finished.
- throw_force, output, 10: latched force magnitude 0..FORCE_MAX.
- enable, output, 1: throw request level to the downstream throw controller.
- charging, output, 1: high while the meter oscillates (HUD bar).

Function
REQ-003 btn SHALL pass a 2-flop synchronizer; press and release events are rising and falling edges of the synchronized signal, one cycle each.
REQ-004 A tick SHALL be a one-cycle pulse every TICK_DIV clk cycles from a free-running prescaler; the prescaler wraps at TICK_DIV-1 and is never cleared by the FSM.
REQ-005 States SHALL be IDLE, CHARGE, THROW, COOLDOWN.
REQ-006 IDLE: enable=0, charging=0; a press with turn_active=1 SHALL go to CHARGE with throw_force=0 and direction=up; a press with turn_active=0 is ignored.
REQ-007 CHARGE: charging=1; on each tick throw_force SHALL move by FORCE_STEP in the current direction.
REQ-008 Upward step reaching or exceeding FORCE_MAX SHALL saturate to FORCE_MAX and set direction=down.
REQ-009 Downward step reaching or going below 0 SHALL saturate to 0 and set direction=up.
REQ-010 Arithmetic for REQ-008/009 SHALL be 11-bit unsigned with explicit compare; no wrap is permitted.
REQ-011 A release in CHARGE SHALL freeze throw_force (any tick in the same cycle is ignored) and go to THROW; enable rises the next cycle.
REQ-012 turn_active=0 in CHARGE SHALL go to IDLE with throw_force=0; release in the same cycle is ignored.
REQ-013 THROW: enable=1 and throw_force SHALL be held constant; a throw_done pulse or THROW_TIMEOUT ticks SHALL go to COOLDOWN.
REQ-014 btn activity in THROW SHALL be ignored.
REQ-015 throw_done SHALL be ignored in every state except THROW.
REQ-016 COOLDOWN: enable=0; the FSM SHALL stay until the synchronized btn is low and one tick has elapsed, then go to IDLE, so a held button cannot retrigger.
REQ-017 throw_force SHALL keep its last value in COOLDOWN and IDLE until the next CHARGE entry.

Reset
REQ-018 rst_n low SHALL asynchronously set state=IDLE, throw_force=0, enable=0, charging=0, direction=up, synchronizer flops=0, prescaler=0, timeout counter=0.
REQ-019 Reset asserted mid-CHARGE or mid-THROW SHALL abort with no enable glitch; enable is a registered output.
REQ-020 Reset release SHALL take effect on the first clk edge after deassertion; a button held through reset SHALL NOT produce a press.

Structure
REQ-021 The state typedef and the FORCE_MAX default SHALL live in shared package throw_pkg, imported by this block and by the throw controllers.
REQ-022 The prescaler SHALL be sub-module tick_gen (param DIV, outputs tick).
REQ-023 The synchronizer and edge detect SHALL remain inline.

Verification (TICK_DIV=4, FORCE_STEP=2, FORCE_MAX=100, THROW_TIMEOUT=20)
REQ-024 Press with turn_active=1, release after 10 ticks -> throw_force=20; enable=1 one cycle after release; charging=0.
REQ-025 Hold 60 ticks -> force reaches 100 at tick 50, then falls to 80 at tick 60; release -> throw_force=80.
REQ-026 FORCE_STEP=3 held 34 ticks -> force saturates at 100, never 102; subsequent ticks give 97, 94, ...
REQ-027 THROW with no throw_done -> enable drops after 20 ticks; with throw_done at tick 5 -> enable drops the next cycle.
REQ-028 Button held through COOLDOWN -> no new CHARGE until released and pressed again; press with turn_active=0 -> stays IDLE.
REQ-029 rst_n low mid-THROW -> enable=0 and throw_force=0 immediately, without waiting for a clk edge.
